dvi_timing_ctrl: RTL and testbench

Video timing controller that sequences the DVI generator. Produces the per-pixel control stream that feeds `dvi_generator`: `de`, `ctrl0`/`ctrl1`/`ctrl2`, and 8-bit `red`/`grn`/`blu`. Pulls pixels from an upstream source over a valid/ready handshake. Runs in the pixel (`clk`) domain, upstream of the TMDS encoders.

---
 rtl/dvi_timing_ctrl_pkg.sv | 19 +
 rtl/dvi_timing_ctrl_if.sv | 9 +
 rtl/dvi_timing_ctrl_video_counter.sv | 30 +++
 rtl/dvi_timing_ctrl.sv | 128 ++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dvi_timing_ctrl_pkg.sv
// Shared types and default 640x480@60 timing for the DVI timing controller.
package dvi_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// Upstream pixel stream: valid/ready handshake carrying {red,grn,blu}.
interface dvi_timing_ctrl_if;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        pix_ready;

  modport master (output pix_valid, output pix_rgb, input pix_ready);
  modport slave  (input pix_valid, input pix_rgb, output pix_ready);
endinterface

// File: rtl/dvi_timing_ctrl_video_counter.sv
// Wrap counter 0..MAX with increment enable, wrap pulse and synchronous clear.
module video_counter #(
  parameter int W   = 12,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;

endmodule

// File: rtl/dvi_timing_ctrl.sv
// Pixel-domain video timing: h/v counters, sync decode, pixel pull and a
// registered output stage feeding the DVI generator.
module dvi_timing_ctrl
  import dvi_pkg::*;
#(
  parameter int          H_ACTIVE      = DEF_H_ACTIVE,
  parameter int          H_FP          = DEF_H_FP,
  parameter int          H_SYNC        = DEF_H_SYNC,
  parameter int          H_BP          = DEF_H_BP,
  parameter int          V_ACTIVE      = DEF_V_ACTIVE,
  parameter int          V_FP          = DEF_V_FP,
  parameter int          V_SYNC        = DEF_V_SYNC,
  parameter int          V_BP          = DEF_V_BP,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          CW            = 12,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  dvi_timing_ctrl_if.slave    pix,
  output logic                sof,
  output logic                underflow,
  input  logic                clr_underflow,
  output logic                de,
  output logic [7:0]          red,
  output logic [7:0]          grn,
  output logic [7:0]          blu,
  output logic [1:0]          ctrl0,
  output logic [1:0]          ctrl1,
  output logic [1:0]          ctrl2,
  output logic [CW-1:0]       x,
  output logic [CW-1:0]       y
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0]    SYNC_IDLE = {~VS_POL, ~HS_POL};

  state_e        state_q, state_d;
  logic [CW-1:0] h_q, v_q;
  logic          h_wrap, v_wrap;
  logic          running, active, ready, hs_act, vs_act;

  logic          de_q, de_d, uf_q, uf_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] x_q, y_q;

  // Counters are held at zero while idle so RUN always starts at h=0, v=0.
  video_counter #(.W(CW), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk(clk), .rst(rst), .clr_i(!running), .inc_i(running),
    .cnt_o(h_q), .wrap_o(h_wrap));

  video_counter #(.W(CW), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk(clk), .rst(rst), .clr_i(!running), .inc_i(h_wrap),
    .cnt_o(v_q), .wrap_o(v_wrap));

  assign running = (state_q != ST_IDLE);
  assign active  = (h_q < H_ACT) && (v_q < V_ACT);
  assign ready   = running && active;
  assign hs_act  = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act  = (v_q >= VS_BEG) && (v_q < VS_END);

  assign pix.pix_ready = ready;
  assign sof           = running && (h_q == '0) && (v_q == '0);

  // v_wrap marks the last clock of the frame; STOP only drops out there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: if (en) state_d = ST_RUN;
               else if (v_wrap) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;

  always_comb begin
    de_d   = ready;
    rgb_d  = '0;
    sync_d = SYNC_IDLE;
    uf_d   = uf_q;
    if (ready) rgb_d = pix.pix_valid ? pix.pix_rgb : UNDERFLOW_RGB;
    if (running) sync_d = {vs_act ? VS_POL : ~VS_POL, hs_act ? HS_POL : ~HS_POL};
    if (ready && !pix.pix_valid) uf_d = 1'b1;
    else if (clr_underflow)      uf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      de_q   <= 1'b0;
      rgb_q  <= '0;
      sync_q <= SYNC_IDLE;
      uf_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      de_q   <= de_d;
      rgb_q  <= rgb_d;
      sync_q <= sync_d;
      uf_q   <= uf_d;
      x_q    <= h_q;
      y_q    <= v_q;
    end

  assign de             = de_q;
  assign {red, grn, blu} = rgb_q;
  assign ctrl0          = sync_q;
  assign ctrl1          = 2'b00;
  assign ctrl2          = 2'b00;
  assign underflow      = uf_q;
  assign x              = x_q;
  assign y              = y_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench for dvi_timing_ctrl on a shrunken raster with a cycle model
// and a pixel scoreboard.
module tb_dvi_timing_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit HSP = 1'b0, VSP = 1'b0;
  localparam logic [23:0] UF = 24'hC0FFEE;

  logic        clk, rst_n, en, clr;
  logic        sof, underflow, de;
  logic [7:0]  red, grn, blu;
  logic [1:0]  ctrl0, ctrl1, ctrl2;
  logic [11:0] x, y;

  dvi_timing_ctrl_if pi();

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CW(12), .UNDERFLOW_RGB(UF)
  ) dut (
    .clk(clk), .rst(rst_n), .en(en), .pix(pi),
    .sof(sof), .underflow(underflow), .clr_underflow(clr),
    .de(de), .red(red), .grn(grn), .blu(blu),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2), .x(x), .y(y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int de_cnt, sof_cnt, rdy_cnt, hs_lo, vs_lo, ufpix;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 stop
  int          mst, mh, mv;
  logic        mu, exp_de;
  logic [1:0]  exp_ctrl;
  logic [47:0] sbq[$];

  function automatic bit m_rdy();
    return (mst != 0) && (mh < HA) && (mv < VA);
  endfunction
  function automatic bit m_sof();
    return (mst != 0) && (mh == 0) && (mv == 0);
  endfunction
  function automatic bit m_hs();
    return (mh >= HA + HF) && (mh < HA + HF + HS);
  endfunction
  function automatic bit m_vs();
    return (mv >= VA + VF) && (mv < VA + VF + VS);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst <= 0; mh <= 0; mv <= 0; mu <= 1'b0;
      exp_de <= 1'b0; exp_ctrl <= 2'b11;
      sbq.delete();
    end else begin
      exp_de   <= m_rdy();
      exp_ctrl <= (mst != 0) ? {m_vs() ? VSP : ~VSP, m_hs() ? HSP : ~HSP} : {~VSP, ~HSP};
      if (m_rdy()) sbq.push_back({12'(mh), 12'(mv), pi.pix_valid ? pi.pix_rgb : UF});
      if (m_rdy() && !pi.pix_valid) mu <= 1'b1;
      else if (clr)                 mu <= 1'b0;
      case (mst)
        0: if (en) mst <= 1;
        1: if (!en) mst <= 2;
        default: if (en) mst <= 1;
                 else if (mh == HT - 1 && mv == VT - 1) mst <= 0;
      endcase
      if (mst == 0) begin
        mh <= 0; mv <= 0;
      end else if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else mh <= mh + 1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("pix_ready", pi.pix_ready, m_rdy());
    chk("sof", sof, m_sof());
    chk("de", de, exp_de);
    chk("ctrl0", ctrl0, exp_ctrl);
    chk("ctrl12", {ctrl1, ctrl2}, 0);
    chk("underflow", underflow, mu);
    if (de === 1'b1) begin
      chk("sb_nonempty", sbq.size() > 0, 1);
      if (sbq.size() > 0) chk("pixel", {x, y, red, grn, blu}, sbq.pop_front());
    end
    de_cnt  <= de_cnt + int'(de === 1'b1);
    sof_cnt <= sof_cnt + int'(sof === 1'b1);
    rdy_cnt <= rdy_cnt + int'(pi.pix_ready === 1'b1);
    hs_lo   <= hs_lo + int'(ctrl0[0] === 1'b0);
    vs_lo   <= vs_lo + int'(ctrl0[1] === 1'b0);
    ufpix   <= ufpix + int'(de === 1'b1 && {red, grn, blu} === UF);
  end

  task automatic clr_cnt();
    de_cnt = 0; sof_cnt = 0; rdy_cnt = 0; hs_lo = 0; vs_lo = 0; ufpix = 0;
  endtask

  task automatic step(input bit v);
    bit xf;
    pi.pix_valid = v;
    xf = pi.pix_ready && v;
    @(posedge clk); #1;
    if (xf) pi.pix_rgb = pi.pix_rgb + 24'd1;
  endtask

  task automatic wait_sof(input string tag);
    int g = 0;
    while (sof !== 1'b1 && g < 4 * FT) begin step(1); g++; end
    chk(tag, sof, 1);
  endtask

  initial begin
    int n, g;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    pi.pix_valid = 1'b0; pi.pix_rgb = 24'h0;
    clr_cnt();
    #22;
    chk("rst_outs", {de, red, grn, blu, x, y}, 0);
    chk("rst_ctrl0", ctrl0, 2'b11);
    chk("rst_ctrl12", {ctrl1, ctrl2}, 0);
    chk("rst_flags", {pi.pix_ready, sof, underflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Disabled: nothing requested
    repeat (30) step(1);
    chk("idle_no_ready", rdy_cnt, 0);
    chk("idle_ctrl0", ctrl0, 2'b11);

    // Two full frames with continuous data
    en = 1'b1; clr_cnt();
    repeat (2 * FT) step(1);
    chk("sof_count", sof_cnt, 2);
    chk("de_count", de_cnt, 2 * HA * VA);
    chk("hsync_low", hs_lo, 2 * HS * VT);
    chk("vsync_low", vs_lo, 2 * VS * HT);
    chk("no_underflow", underflow, 0);

    // Starvation on three active cycles
    clr_cnt();
    n = 0; g = 0;
    while (n < 3 && g < 4 * FT) begin
      if (pi.pix_ready === 1'b1) n++;
      step(0); g++;
    end
    chk("starve_found", n, 3);
    repeat (2) step(1);
    chk("uf_pixels", ufpix, 3);
    chk("uf_set", underflow, 1);
    repeat (20) step(1);
    chk("uf_sticky", underflow, 1);
    g = 0;
    while (pi.pix_ready !== 1'b1 && g < 4 * FT) begin step(1); g++; end
    chk("ready_wait", pi.pix_ready, 1);
    clr = 1'b1; step(0); clr = 1'b0;
    chk("uf_set_wins", underflow, 1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("uf_cleared", underflow, 0);

    // Disable on line 2: frame completes, then idle
    wait_sof("sof_before_stop");
    repeat (2 * HT) step(1);
    en = 1'b0; clr_cnt();
    repeat (2 * FT) step(1);
    chk("stop_de", de_cnt, (VA - 2) * HA);
    chk("stop_no_sof", sof_cnt, 0);
    chk("stop_ready", rdy_cnt, (VA - 2) * HA);
    chk("stop_idle", {pi.pix_ready, de}, 0);
    en = 1'b1;
    wait_sof("restart_sof");
    step(1);
    chk("restart_xy", {de, x, y}, {1'b1, 24'h0});

    // Asynchronous reset in the middle of an active line
    wait_sof("sof_before_rst");
    repeat (3) step(1);
    chk("midline_de", de, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_de_rgb", {de, red, grn, blu}, 0);
    chk("arst_ready", pi.pix_ready, 0);
    chk("arst_xy", {x, y}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sof("post_rst_sof");
    step(1);
    chk("post_rst_xy", {de, x, y}, {1'b1, 24'h0});
    repeat (2 * HT) step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
